// File: rtl/latmem_pkg.sv
// Shared constants and helpers for the latency-configurable memory responder.
// The optional range check is controlled by LATMEM_BOUNDS_CHECK_EN (see latency_mem.sv).
package latmem_pkg;

    // Data returned for a read that falls outside the storage array
    localparam logic [31:0] BAD_ADDR_DATA = 32'hDEADBEEF;

    // Upper limits for the timing parameters, checked at elaboration
    localparam int MAX_LATENCY  = 16;
    localparam int MAX_INTERVAL = 16;

    // Interval counter width, wide enough to hold MAX_INTERVAL-1
    localparam int CNT_W = $clog2(MAX_INTERVAL);

    // Turns a 4-bit byte-lane enable into a 32-bit bit mask
    function automatic logic [31:0] mask_expand(input logic [3:0] mask);
        logic [31:0] bits;
        bits = '0;
        for (int n = 0; n < 4; n++) begin
            bits[8*n +: 8] = {8{mask[n]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/latmem_delay_line.sv
// Fixed-depth shift register that carries a valid bit (MSB) plus payload.
// Only the valid bits are reset; payload bits are don't-care while invalid.
module latmem_delay_line #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-2:0] data_q [DEPTH];
    logic [WIDTH-2:0] data_d [DEPTH];

    // Next stage contents: new entry enters stage 0, everything else moves up one
    always_comb begin
        valid_d[0] = i_data[WIDTH-1];
        data_d[0]  = i_data[WIDTH-2:0];
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    // Valid bits drop to zero immediately on reset so in-flight entries are lost
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload shifts every cycle and needs no reset
    always_ff @(posedge i_clk) begin
        data_q <= data_d;
    end

    assign o_data = {valid_q[DEPTH-1], data_q[DEPTH-1]};

endmodule

// File: rtl/latency_mem.sv
// Latency-configurable memory responder: one request per INTERVAL cycles,
// writes commit at acceptance, reads answer exactly LATENCY cycles later.
// Optional macro LATMEM_BOUNDS_CHECK_EN: addresses >= SIZE are out of range
// (writes dropped, reads return BAD_ADDR_DATA); otherwise addresses wrap.
module latency_mem
    import latmem_pkg::*;
#(
    parameter int SIZE     = 1024,
    parameter int LATENCY  = 4,
    parameter int INTERVAL = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_ready,
    input  logic [31:0] i_addr,
    input  logic        i_ren,
    input  logic        i_wen,
    input  logic [3:0]  i_mask,
    input  logic [31:0] i_wdata,
    output logic        o_valid,
    output logic [31:0] o_rdata
);

    localparam int WORDS = SIZE / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    if ((SIZE < 4) || ((SIZE % 4) != 0)) begin : g_bad_size
        $error("latency_mem: SIZE must be a positive multiple of 4");
    end
    if ((LATENCY < 1) || (LATENCY > MAX_LATENCY)) begin : g_bad_latency
        $error("latency_mem: LATENCY out of range");
    end
    if ((INTERVAL < 1) || (INTERVAL > MAX_INTERVAL)) begin : g_bad_interval
        $error("latency_mem: INTERVAL out of range");
    end

    // Word storage; preloaded externally, never reset
    logic [31:0] mem [0:WORDS-1];

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             req_accept;
    logic             wr_accept;
    logic             rd_accept;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      lane_mask;
    logic [31:0]      rd_word;
    logic [32:0]      line_in;
    logic [32:0]      line_out;
    logic             unused_addr_lsbs;

    // Byte offset within a word plays no role in addressing
    assign unused_addr_lsbs = ^i_addr[1:0];

    assign word_idx  = IDX_W'(i_addr[31:2] % 30'(WORDS));
    assign lane_mask = mask_expand(i_mask);

`ifdef LATMEM_BOUNDS_CHECK_EN
    assign in_range = (i_addr < 32'(SIZE));
    assign rd_word  = in_range ? mem[word_idx] : BAD_ADDR_DATA;
`else
    assign in_range = 1'b1;
    assign rd_word  = mem[word_idx];
`endif

    // Ready depends only on the counter and reset, never on the request lines
    assign o_ready    = !i_rst && (cnt_q == '0);
    assign req_accept = o_ready && (i_ren || i_wen);
    assign wr_accept  = req_accept && i_wen && in_range;
    assign rd_accept  = req_accept && i_ren && !i_wen;

    // Reload the interval counter on every accepted request, else count down to zero
    always_comb begin
        cnt_d = cnt_q;
        if (req_accept) begin
            cnt_d = CNT_W'(INTERVAL - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Interval counter register, cleared immediately by reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Merge enabled write lanes into the addressed word at the acceptance edge
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem[word_idx] <= (mem[word_idx] & ~lane_mask) | (i_wdata & lane_mask);
        end
    end

    // Read data is sampled now and masked before entering the delay line
    assign line_in = {rd_accept, rd_word & lane_mask};

    latmem_delay_line #(
        .WIDTH(33),
        .DEPTH(LATENCY)
    ) u_delay (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_data(line_in),
        .o_data(line_out)
    );

    assign o_valid = line_out[32];
    assign o_rdata = line_out[32] ? line_out[31:0] : 32'h0;

endmodule
